pma_rule_table: RTL and testbench

// - Run-time programmable physical-memory-attribute (PMA) table for the CVA6 subsystem.
// - Generalises compile-time ExecuteRegion/CachedRegion/NonIdempotent rules into NrRules programmable,

---
 rtl/pma_pkg.sv | 28 ++
 rtl/pma_range_match.sv | 18 +
 rtl/pma_rule_table.sv | 187 ++++++++++++++++++
 tb/tb_pma_rule_table.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// Shared types for the programmable PMA rule table.
package pma_pkg;

    // Storage width of a rule's base/length; the table's AddrWidth must not exceed it.
    localparam int unsigned PmaAw = 64;

    typedef struct packed {
        logic lock;
        logic nonidem;
        logic cached;
        logic exec;
        logic en;
    } pma_attr_t;

    typedef enum logic [1:0] {
        PMA_BASE = 2'd0,
        PMA_LEN  = 2'd1,
        PMA_ATTR = 2'd2,
        PMA_RSVD = 2'd3
    } pma_field_e;

    typedef struct packed {
        logic [PmaAw-1:0] base;
        logic [PmaAw-1:0] len;
        pma_attr_t        attr;
    } pma_rule_t;

endpackage

// File: rtl/pma_range_match.sv
// One rule against one address: en && base <= a < base+len, end computed one bit wider.
module pma_range_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] len_i,
    input  logic                 en_i,
    output logic                 match_o
);

    logic [AddrWidth:0] end_excl;

    // The extra carry bit lets a region ending exactly at 2^AddrWidth match without wrapping.
    assign end_excl = {1'b0, base_i} + {1'b0, len_i};
    assign match_o  = en_i && (len_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < end_excl);

endmodule

// File: rtl/pma_rule_table.sv
// Programmable, lockable PMA rule table with a registered config port and
// NrPorts independent single-cycle lookup pipelines.
module pma_rule_table
    import pma_pkg::*;
#(
    parameter int unsigned NrRules     = 8,
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned AddrWidth   = 64,
    parameter pma_attr_t   DefaultAttr = 5'b00100,
    localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1,
    localparam int unsigned CfgAw      = IdxW + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_req_i,
    input  logic                         cfg_we_i,
    input  logic [CfgAw-1:0]             cfg_addr_i,
    input  logic [AddrWidth-1:0]         cfg_wdata_i,
    output logic                         cfg_rvalid_o,
    output logic [AddrWidth-1:0]         cfg_rdata_o,
    output logic                         cfg_err_o,
    input  logic [NrPorts-1:0]           lu_valid_i,
    input  logic [NrPorts*AddrWidth-1:0] lu_addr_i,
    output logic [NrPorts-1:0]           lu_valid_o,
    output logic [NrPorts-1:0]           lu_hit_o,
    output logic [NrPorts*IdxW-1:0]      lu_idx_o,
    output logic [NrPorts*5-1:0]         lu_attr_o
);

    // ---------------- rule storage and config port ----------------
    pma_rule_t rules_q [NrRules];
    pma_rule_t rules_d [NrRules];

    logic [IdxW-1:0]      cfg_idx;
    pma_field_e           cfg_field;
    logic                 cfg_idx_ok;
    pma_rule_t            sel_rule;
    pma_rule_t            upd_rule;
    logic                 cfg_rvalid_q;
    logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;
    logic                 cfg_err_q, cfg_err_d;

    assign cfg_idx    = cfg_addr_i[CfgAw-1:2];
    assign cfg_field  = pma_field_e'(cfg_addr_i[1:0]);
    assign cfg_idx_ok = (32'(cfg_idx) < NrRules);

    // Decode a config access: select the rule, apply lock/enable write protection, build read data.
    always_comb begin
        rules_d     = rules_q;
        cfg_rdata_d = '0;
        cfg_err_d   = 1'b0;
        sel_rule    = '0;
        for (int i = 0; i < NrRules; i++) begin
            if (cfg_idx == IdxW'(i)) sel_rule = rules_q[i];
        end
        upd_rule = sel_rule;
        if (cfg_req_i) begin
            if (!cfg_idx_ok) begin
                cfg_err_d = 1'b1;
            end else begin
                case (cfg_field)
                    PMA_BASE: begin
                        if (cfg_we_i) begin
                            if (sel_rule.attr.lock || sel_rule.attr.en) cfg_err_d = 1'b1;
                            else upd_rule.base = PmaAw'(cfg_wdata_i);
                        end else begin
                            cfg_rdata_d = AddrWidth'(sel_rule.base);
                        end
                    end
                    PMA_LEN: begin
                        if (cfg_we_i) begin
                            if (sel_rule.attr.lock || sel_rule.attr.en) cfg_err_d = 1'b1;
                            else upd_rule.len = PmaAw'(cfg_wdata_i);
                        end else begin
                            cfg_rdata_d = AddrWidth'(sel_rule.len);
                        end
                    end
                    PMA_ATTR: begin
                        // A write that sets lock is itself accepted; only later writes bounce.
                        if (cfg_we_i) begin
                            if (sel_rule.attr.lock) cfg_err_d = 1'b1;
                            else upd_rule.attr = pma_attr_t'(cfg_wdata_i[4:0]);
                        end else begin
                            cfg_rdata_d[4:0] = sel_rule.attr;
                        end
                    end
                    default: begin
                        if (cfg_we_i) cfg_err_d = 1'b1;
                    end
                endcase
            end
        end
        for (int i = 0; i < NrRules; i++) begin
            if (cfg_req_i && cfg_we_i && cfg_idx_ok && !cfg_err_d && (cfg_idx == IdxW'(i)))
                rules_d[i] = upd_rule;
        end
    end

    // Rule table state; reset clears everything including lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) rules_q[i] <= '0;
        end else begin
            for (int i = 0; i < NrRules; i++) rules_q[i] <= rules_d[i];
        end
    end

    // One-stage config response register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_rvalid_q <= cfg_req_i;
            cfg_rdata_q  <= cfg_rdata_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign cfg_err_o    = cfg_err_q;

    // ---------------- lookup ports ----------------
    logic [NrPorts-1:0][NrRules-1:0] match;

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        for (genvar r = 0; r < NrRules; r++) begin : g_rule
            pma_range_match #(.AddrWidth(AddrWidth)) u_match (
                .addr_i  (lu_addr_i[p*AddrWidth +: AddrWidth]),
                .base_i  (rules_q[r].base[AddrWidth-1:0]),
                .len_i   (rules_q[r].len[AddrWidth-1:0]),
                .en_i    (rules_q[r].attr.en),
                .match_o (match[p][r])
            );
        end
    end

    logic      [NrPorts-1:0]           hit_d,   hit_q;
    logic      [NrPorts-1:0][IdxW-1:0] idx_d,   idx_q;
    pma_attr_t [NrPorts-1:0]           attr_d,  attr_q;
    logic      [NrPorts-1:0]           valid_q;

    // Priority encode per port (lowest index wins) and zero everything on idle ports.
    always_comb begin
        hit_d  = '0;
        idx_d  = '0;
        attr_d = '0;
        for (int p = 0; p < NrPorts; p++) begin
            attr_d[p] = DefaultAttr;
            for (int r = int'(NrRules) - 1; r >= 0; r--) begin
                if (match[p][r]) begin
                    hit_d[p]  = 1'b1;
                    idx_d[p]  = IdxW'(r);
                    attr_d[p] = rules_q[r].attr;
                end
            end
            if (!lu_valid_i[p]) begin
                hit_d[p]  = 1'b0;
                idx_d[p]  = '0;
                attr_d[p] = '0;
            end
        end
    end

    // Lookup result pipeline register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            hit_q   <= '0;
            idx_q   <= '0;
            attr_q  <= '0;
        end else begin
            valid_q <= lu_valid_i;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            attr_q  <= attr_d;
        end
    end

    assign lu_valid_o = valid_q;
    assign lu_hit_o   = hit_q;
    assign lu_idx_o   = idx_q;
    assign lu_attr_o  = attr_q;

endmodule

// File: tb/tb_pma_rule_table.sv
// Directed + random bench for pma_rule_table against a behavioural table model.
module tb_pma_rule_table;

    localparam int NR = 6;  // non power of two so out-of-range rule indices are reachable
    localparam int NP = 2;
    localparam int AW = 64;
    localparam logic [4:0] DEF = 5'b00100;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            cfg_req_i = 1'b0;
    logic            cfg_we_i = 1'b0;
    logic [4:0]      cfg_addr_i = '0;
    logic [AW-1:0]   cfg_wdata_i = '0;
    logic            cfg_rvalid_o;
    logic [AW-1:0]   cfg_rdata_o;
    logic            cfg_err_o;
    logic [NP-1:0]   lu_valid_i = '0;
    logic [NP*AW-1:0] lu_addr_i = '0;
    logic [NP-1:0]   lu_valid_o;
    logic [NP-1:0]   lu_hit_o;
    logic [NP*3-1:0] lu_idx_o;
    logic [NP*5-1:0] lu_attr_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the table
    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [4:0]  m_attr [NR];

    pma_rule_table #(.NrRules(NR), .NrPorts(NP), .AddrWidth(AW), .DefaultAttr(DEF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
        .lu_valid_i(lu_valid_i), .lu_addr_i(lu_addr_i),
        .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_idx_o(lu_idx_o), .lu_attr_o(lu_attr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = '0; m_len[i] = '0; m_attr[i] = '0;
        end
    endfunction

    // First (lowest) rule whose region contains a; region end is exact, not modular.
    function automatic void model_lookup(input logic [63:0] a, output logic h,
                                         output logic [2:0] ix, output logic [4:0] at);
        h = 1'b0; ix = '0; at = DEF;
        for (int i = 0; i < NR; i++) begin
            if (!h && m_attr[i][0] && m_len[i] != 0 && a >= m_base[i] &&
                ({1'b0, a} < {1'b0, m_base[i]} + {1'b0, m_len[i]})) begin
                h = 1'b1; ix = 3'(i); at = m_attr[i];
            end
        end
    endfunction

    function automatic void model_cfg(input logic we, input logic [4:0] addr, input logic [63:0] wd,
                                      output logic err, output logic [63:0] rd);
        int idx;
        idx = int'(addr[4:2]);
        err = 1'b0; rd = '0;
        if (idx >= NR) begin
            err = 1'b1;
        end else begin
            case (addr[1:0])
                2'd0: if (!we) rd = m_base[idx];
                      else if (m_attr[idx][4] || m_attr[idx][0]) err = 1'b1;
                      else m_base[idx] = wd;
                2'd1: if (!we) rd = m_len[idx];
                      else if (m_attr[idx][4] || m_attr[idx][0]) err = 1'b1;
                      else m_len[idx] = wd;
                2'd2: if (!we) rd = {59'd0, m_attr[idx]};
                      else if (m_attr[idx][4]) err = 1'b1;
                      else m_attr[idx] = wd[4:0];
                default: if (we) err = 1'b1;
            endcase
        end
    endfunction

    function automatic logic [4:0] ca(input int idx, input int fld);
        return {3'(idx), 2'(fld)};
    endfunction

    // One clock: drive config + lookups, predict from pre-access model state, check the response.
    task automatic step(input logic req, input logic we, input logic [4:0] addr, input logic [63:0] wd,
                        input logic [1:0] lv, input logic [63:0] a0, input logic [63:0] a1);
        logic       eh [NP];
        logic [2:0] ei [NP];
        logic [4:0] ea [NP];
        logic       eerr;
        logic [63:0] erd;
        model_lookup(a0, eh[0], ei[0], ea[0]);
        model_lookup(a1, eh[1], ei[1], ea[1]);
        eerr = 1'b0; erd = '0;
        if (req) model_cfg(we, addr, wd, eerr, erd);
        cfg_req_i = req; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd;
        lu_valid_i = lv; lu_addr_i = {a1, a0};
        @(posedge clk_i); #1;
        cfg_req_i = 1'b0; lu_valid_i = '0;
        chk("cfg_rvalid", 64'(cfg_rvalid_o), 64'(req));
        if (req) chk("cfg_err", 64'(cfg_err_o), 64'(eerr));
        if (req && !we) chk("cfg_rdata", cfg_rdata_o, erd);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("lu_valid%0d", p), 64'(lu_valid_o[p]), 64'(lv[p]));
            chk($sformatf("lu_hit%0d", p), 64'(lu_hit_o[p]), lv[p] ? 64'(eh[p]) : 64'd0);
            chk($sformatf("lu_idx%0d", p), 64'(lu_idx_o[p*3 +: 3]), lv[p] ? 64'(ei[p]) : 64'd0);
            chk($sformatf("lu_attr%0d", p), 64'(lu_attr_o[p*5 +: 5]), lv[p] ? 64'(ea[p]) : 64'd0);
        end
    endtask

    task automatic wr(input int idx, input int fld, input logic [63:0] wd);
        step(1'b1, 1'b1, ca(idx, fld), wd, 2'b00, '0, '0);
    endtask

    task automatic rd(input int idx, input int fld);
        step(1'b1, 1'b0, ca(idx, fld), '0, 2'b00, '0, '0);
    endtask

    task automatic look(input logic [63:0] a0, input logic [63:0] a1);
        step(1'b0, 1'b0, '0, '0, 2'b11, a0, a1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rvalid"}, 64'(cfg_rvalid_o), 64'd0);
        chk({tag, "_rdata"}, cfg_rdata_o, 64'd0);
        chk({tag, "_err"}, 64'(cfg_err_o), 64'd0);
        chk({tag, "_luv"}, 64'(lu_valid_o), 64'd0);
        chk({tag, "_hit"}, 64'(lu_hit_o), 64'd0);
        chk({tag, "_idx"}, 64'(lu_idx_o), 64'd0);
        chk({tag, "_attr"}, 64'(lu_attr_o), 64'd0);
    endtask

    initial begin
        model_reset();
        #2 rst_ni = 1'b0;
        #3 chk_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(1'b0, 1'b0, '0, '0, 2'b00, '0, '0);
        look(64'h0, 64'h8000_0000);  // empty table: miss with default attr

        // Basic region, inclusive start / exclusive end
        wr(0, 0, 64'h8000_0000);
        wr(0, 1, 64'h4000_0000);
        wr(0, 2, 64'h07);
        look(64'hBFFF_FFFF, 64'hC000_0000);
        look(64'h8000_0000, 64'h7FFF_FFFF);
        rd(0, 0); rd(0, 1); rd(0, 2);

        // Priority between overlapping rules 0 and 3
        wr(0, 2, 64'h0);
        wr(0, 0, 64'h1_0000);
        wr(0, 1, 64'h100);
        wr(3, 1, 64'h2_0000);
        wr(3, 2, 64'h0B);
        wr(0, 2, 64'h07);
        look(64'h1_0000, 64'h1_0100);
        wr(0, 2, 64'h0);
        look(64'h1_0000, 64'h1_0000);

        // Locked rule
        wr(2, 0, 64'h5000);
        wr(2, 1, 64'h1000);
        wr(2, 2, 64'h11);
        wr(2, 0, 64'h6000);
        rd(2, 0);
        wr(2, 2, 64'h0);
        rd(2, 2);
        look(64'h5800, 64'h6000);

        // Enabled rule rejects range writes until disabled
        wr(1, 2, 64'h01);
        wr(1, 1, 64'h100);
        wr(1, 2, 64'h0);
        wr(1, 0, 64'h9000_0000);
        wr(1, 1, 64'h100);
        wr(1, 2, 64'h01);
        look(64'h9000_00FF, 64'h9000_0100);

        // Region ending at 2^64, then len=0
        wr(4, 0, 64'hFFFF_FFFF_FFFF_FF00);
        wr(4, 1, 64'h100);
        wr(4, 2, 64'h05);
        look(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FEFF);
        wr(4, 2, 64'h0);
        wr(4, 1, 64'h0);
        wr(4, 2, 64'h05);
        look(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF00);

        // Out-of-range rule index and reserved field
        wr(6, 0, 64'h1234);
        rd(7, 2);
        rd(1, 3);
        wr(1, 3, 64'hFF);

        // Lookup in the same cycle as the enabling write sees the old table
        wr(5, 0, 64'h3000_0000);
        wr(5, 1, 64'h10);
        step(1'b1, 1'b1, ca(5, 2), 64'h09, 2'b11, 64'h3000_0000, 64'h3000_000F);
        look(64'h3000_0000, 64'h3000_000F);

        // Random mix of config accesses and lookups
        for (int k = 0; k < 400; k++) begin
            logic        rq, w;
            logic [4:0]  ad;
            logic [63:0] wd, a0, a1;
            rq = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ad = 5'($urandom);
            if (ad[1:0] == 2'd2) wd = 64'($urandom_range(0, 31) & (($urandom_range(0, 7) == 0) ? 31 : 15));
            else wd = 64'($urandom_range(0, 'h1_FFFF));
            a0 = 64'($urandom_range(0, 'h2_FFFF));
            a1 = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 'h1_FFFF));
            step(rq, w, ad, wd, 2'($urandom), a0, a1);
        end

        // Async reset in the middle of traffic
        look(64'h5800, 64'h1_0000);
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = ca(2, 2);
        lu_valid_i = 2'b11; lu_addr_i = {64'h5800, 64'h1_0000};
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk_i); #1;
        chk_all_zero("midrst_hold");
        cfg_req_i = 1'b0; lu_valid_i = '0;
        rst_ni = 1'b1;
        model_reset();
        rd(2, 2);
        wr(2, 0, 64'h7777);
        rd(2, 0);
        look(64'h5800, 64'h1_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
